bus_arbiter_2: RTL and testbench
================================

BUS_ARBITER_2 -- requirements
Module: bus_arbiter_2

Interface
REQ-001 Parameter: WIDTH, 64, payload and read-data width in bits.
REQ-002 Parameter: TIMEOUT, 15, BUSY cycles without dn_ack before abort (range 1..255).
REQ-003 Ports, one per line, as follows.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0, req1  input  1 each  transaction request; held high until the matching done pulse.
REQ-007 pay0, pay1  input  WIDTH each  requester payload (address/write data).
REQ-008 done0, done1  output  1 each  one-cycle completion pulse to the owning requester.
REQ-009 err  output  1  timeout flag; high only in the cycle a done pulse is high.
REQ-010 rdata_out  output  WIDTH  read data returned with done; zero on timeout.
REQ-011 sel  output  1  registered grant; also the select of the shared payload mux (0=requester 0).
REQ-012 dn_valid  output  1  request to the shared downstream resource.
REQ-013 dn_payload  output  WIDTH  payload of the granted requester, registered and stable while dn_valid is high.
REQ-014 dn_ack  input  1  downstream completion; sampled only in BUSY.
REQ-015 dn_rdata  input  WIDTH  downstream read data; valid with dn_ack.

Function
REQ-016 FSM states SHALL be IDLE, BUSY and RESP.
REQ-017 IDLE: if either req is high, the arbiter SHALL load sel, latch the muxed payload into dn_payload, clear the timeout counter and enter BUSY at the next edge.
REQ-018 Arbitration SHALL be round-robin: a single request wins; on simultaneous requests the requester not served most recently wins.
REQ-019 BUSY: dn_valid SHALL be 1; sel and dn_payload SHALL stay constant.
REQ-020 BUSY with dn_ack=1: the arbiter SHALL register dn_rdata into rdata_out, set err=0 and enter RESP.
REQ-021 BUSY without dn_ack: the counter SHALL increment; when it reaches TIMEOUT, the arbiter SHALL enter RESP with err=1 and rdata_out=0.
REQ-022 dn_ack in the same cycle the counter reaches TIMEOUT SHALL count as success; ack wins.
REQ-023 RESP: done[sel] SHALL be 1 for exactly one cycle, dn_valid SHALL be 0, the priority pointer SHALL update to the served requester, and the next state SHALL be IDLE.
REQ-024 Requesters SHALL drop req at the edge on which they sample done; the arbiter SHALL ignore req in BUSY and RESP.
REQ-025 A req dropped mid-BUSY SHALL NOT abort the transaction; done still pulses.
REQ-026 Latency: a req seen in IDLE at cycle n gives dn_valid at n+1; dn_ack at cycle m gives done at m+1; minimum req-to-done is 2 cycles.
REQ-027 done0 and done1 SHALL never be high together; done and err SHALL be 0 outside RESP.
REQ-028 Back-to-back: with both reqs held, grants SHALL alternate 0,1,0,1 with one IDLE cycle between transactions.

Reset
REQ-029 reset SHALL force, asynchronously: state IDLE, sel=0, pointer favouring requester 0, counter=0, dn_valid=0, done0=done1=err=0, dn_payload=0, rdata_out=0.
REQ-030 A reset asserted during BUSY or RESP SHALL abandon the transaction; no done pulse SHALL follow.
REQ-031 The first arbitration after reset release SHALL occur at the first rising edge with reset low.

Structure
REQ-032 The package bus_arb_pkg SHALL hold the state enum (IDLE, BUSY, RESP) and the default TIMEOUT constant.
REQ-033 The payload select SHALL instantiate mux_64_2_1 (A=pay0, B=pay1, sel=sel next-value); the FSM, counter and pointer SHALL be in bus_arbiter_2.

Verification
REQ-034 Single request: req0=1, pay0=64'h1234, dn_ack 3 cycles after dn_valid, dn_rdata=64'hABCD -> dn_payload=64'h1234, sel=0, done0 pulse, rdata_out=64'hABCD, err=0.
REQ-035 Simultaneous requests after reset: req0=req1=1, immediate acks -> service order 0,1,0,1; done pulses alternate; never both high.
REQ-036 Timeout: req1=1, dn_ack held 0 -> after 15 BUSY cycles, done1 and err pulse together, rdata_out=0.
REQ-037 Ack on limit: dn_ack=1 on the 15th BUSY cycle -> err=0, rdata_out=dn_rdata.
REQ-038 Reset mid-BUSY: reset asserted in the 2nd BUSY cycle -> outputs at reset values immediately, no done after release, next grant goes to requester 0.
REQ-039 Drop mid-transaction: req0 deasserted in BUSY, then dn_ack -> done0 still pulses once, and the arbiter returns to IDLE.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state type and defaults for the two-port bus arbiter
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mux_64_2_1.sv
// rtl/mux_64_2_1.sv - two-input payload multiplexer (sel=0 picks a)
module mux_64_2_1 #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter_2.sv
// rtl/bus_arbiter_2.sv - round-robin arbiter granting one of two requesters a shared downstream port
module bus_arbiter_2
   import bus_arb_pkg::*;
#(
   parameter int WIDTH   = 64,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] pay0,
   input  logic [WIDTH-1:0] pay1,
   output logic             done0,
   output logic             done1,
   output logic             err,
   output logic [WIDTH-1:0] rdata_out,
   output logic             sel,
   output logic             dn_valid,
   output logic [WIDTH-1:0] dn_payload,
   input  logic             dn_ack,
   input  logic [WIDTH-1:0] dn_rdata
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t           state;
   state_t           state_next;
   logic             grant_next;
   logic             prio;
   logic             err_q;
   logic [7:0]       cnt;
   logic [7:0]       cnt_inc;
   logic [WIDTH-1:0] pay_mux;
   logic             req_any;

   assign req_any = req0 | req1;
   assign cnt_inc = cnt + 8'd1;

   // The mux follows the grant being decided this cycle so the payload latches with it.
   mux_64_2_1 #(.WIDTH(WIDTH)) u_pay_mux (
      .a   (pay0),
      .b   (pay1),
      .sel (grant_next),
      .y   (pay_mux)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and grant decision; prio names the requester that wins a tie.
   always_comb begin
      state_next = state;
      grant_next = sel;
      case (state)
         IDLE: begin
            if (req_any) begin
               grant_next = (req0 && req1) ? prio : req1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (dn_ack || (cnt_inc == TIMEOUT_CNT)) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant, payload, timeout counter, response data and round-robin pointer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel        <= 1'b0;
         prio       <= 1'b0;
         cnt        <= 8'd0;
         err_q      <= 1'b0;
         dn_payload <= '0;
         rdata_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  sel        <= grant_next;
                  dn_payload <= pay_mux;
                  cnt        <= 8'd0;
               end
            end
            BUSY: begin
               if (dn_ack) begin
                  rdata_out <= dn_rdata;
                  err_q     <= 1'b0;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == TIMEOUT_CNT) begin
                     rdata_out <= '0;
                     err_q     <= 1'b1;
                  end
               end
            end
            RESP: begin
               prio <= ~sel;
            end
            default: ;
         endcase
      end
   end

   assign dn_valid = (state == BUSY);
   assign done0    = (state == RESP) && !sel;
   assign done1    = (state == RESP) && sel;
   assign err      = (state == RESP) && err_q;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb/tb_bus_arbiter_2.sv - self-checking bench for bus_arbiter_2 with a transaction-level model
module tb_bus_arbiter_2;

   localparam int WIDTH   = 64;
   localparam int TIMEOUT = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic             req0, req1;
   logic [WIDTH-1:0] pay0, pay1;
   logic             done0, done1, err;
   logic [WIDTH-1:0] rdata_out;
   logic             sel;
   logic             dn_valid;
   logic [WIDTH-1:0] dn_payload;
   logic             dn_ack;
   logic [WIDTH-1:0] dn_rdata;

   int n_cmp = 0;
   int n_err = 0;
   int fav   = 0;

   bus_arbiter_2 #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0       (req0),
      .req1       (req1),
      .pay0       (pay0),
      .pay1       (pay1),
      .done0      (done0),
      .done1      (done1),
      .err        (err),
      .rdata_out  (rdata_out),
      .sel        (sel),
      .dn_valid   (dn_valid),
      .dn_payload (dn_payload),
      .dn_ack     (dn_ack),
      .dn_rdata   (dn_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One whole transaction, entered at a falling edge with the arbiter idle.
   // k = BUSY cycles without ack before the ack; k >= TIMEOUT means the ack never comes.
   task automatic run_txn(input logic r0, input logic r1, input logic [63:0] p0,
                          input logic [63:0] p1, input int k, input logic [63:0] rd,
                          input bit drop);
      int          w;
      int          busy_n;
      bit          exp_err;
      logic [63:0] exp_pay;
      logic [63:0] exp_rd;
      chk("idle_dn_valid", dn_valid, 0);
      chk("idle_done0", done0, 0);
      chk("idle_done1", done1, 0);
      chk("idle_err", err, 0);
      w       = (r0 && r1) ? fav : (r1 ? 1 : 0);
      exp_pay = (w == 1) ? p1 : p0;
      exp_err = (k >= TIMEOUT);
      busy_n  = exp_err ? TIMEOUT : k + 1;
      exp_rd  = exp_err ? 64'd0 : rd;
      req0 = r0; req1 = r1; pay0 = p0; pay1 = p1; dn_ack = 1'b0;
      @(negedge clk);
      for (int i = 1; i <= busy_n; i++) begin
         chk("busy_dn_valid", dn_valid, 1);
         chk("busy_sel", sel, 64'(w));
         chk("busy_dn_payload", dn_payload, exp_pay);
         chk("busy_done0", done0, 0);
         chk("busy_done1", done1, 0);
         chk("busy_err", err, 0);
         pay0 = {$urandom, $urandom};
         pay1 = {$urandom, $urandom};
         if (drop && i == 1) begin
            if (w == 1) req1 = 1'b0; else req0 = 1'b0;
         end
         dn_ack   = (i == k + 1);
         dn_rdata = dn_ack ? rd : {$urandom, $urandom};
         @(negedge clk);
      end
      dn_ack = 1'b0;
      chk("resp_done0", done0, 64'(w == 0));
      chk("resp_done1", done1, 64'(w == 1));
      chk("resp_err", err, 64'(exp_err));
      chk("resp_rdata_out", rdata_out, exp_rd);
      chk("resp_dn_valid", dn_valid, 0);
      if (w == 1) req1 = 1'b0; else req0 = 1'b0;
      fav = 1 - w;
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] rr;
      int         k;
      reset = 1'b1;
      req0 = 1'b0; req1 = 1'b0; pay0 = '0; pay1 = '0;
      dn_ack = 1'b0; dn_rdata = '0;

      @(negedge clk);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_sel", sel, 0);
      chk("rst_dn_payload", dn_payload, 0);
      chk("rst_rdata_out", rdata_out, 0);
      chk("rst_done0", done0, 0);
      chk("rst_done1", done1, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;
      @(negedge clk);

      // single request, ack three cycles after dn_valid
      run_txn(1'b1, 1'b0, 64'h1234, 64'h5555, 3, 64'hABCD, 1'b0);

      // simultaneous requests, immediate acks
      for (int i = 0; i < 4; i++)
         run_txn(1'b1, 1'b1, 64'h100 + 64'(i), 64'h200 + 64'(i), 0, 64'hD0 + 64'(i), 1'b0);

      // timeout, ack exactly on the limit, and one cycle past it
      run_txn(1'b0, 1'b1, 64'h77, 64'h88, 100, 64'hDEAD, 1'b0);
      run_txn(1'b0, 1'b1, 64'h99, 64'hAA, TIMEOUT - 1, 64'hBEEF, 1'b0);
      run_txn(1'b0, 1'b1, 64'h99, 64'hAB, TIMEOUT, 64'hBEEF, 1'b0);

      // request dropped mid-transaction
      run_txn(1'b1, 1'b0, 64'hC0FFEE, 64'h0, 2, 64'hF00D, 1'b1);

      // reset in the second BUSY cycle of a requester-1 transaction
      req1 = 1'b1; pay1 = 64'h4242;
      @(negedge clk);
      chk("rb_busy1_dn_valid", dn_valid, 1);
      @(negedge clk);
      #1 reset = 1'b1;
      req1 = 1'b0;
      #1;
      chk("rb_dn_valid", dn_valid, 0);
      chk("rb_sel", sel, 0);
      chk("rb_dn_payload", dn_payload, 0);
      chk("rb_rdata_out", rdata_out, 0);
      chk("rb_done0", done0, 0);
      chk("rb_done1", done1, 0);
      chk("rb_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      fav   = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rb_no_done0", done0, 0);
         chk("rb_no_done1", done1, 0);
         chk("rb_no_valid", dn_valid, 0);
      end
      run_txn(1'b1, 1'b1, 64'h11, 64'h22, 1, 64'h33, 1'b0);

      // randomized transactions
      for (int t = 0; t < 40; t++) begin
         rr = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) < 7) k = $urandom_range(0, 4);
         else                          k = TIMEOUT - 2 + $urandom_range(0, 4);
         run_txn(rr[0], rr[1], {$urandom, $urandom}, {$urandom, $urandom}, k,
                 {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
